pmc_ac_loader: RTL and testbench
================================

Name: pmc_ac_loader

Overview:
- Serial configuration sequencer for the pixel matrix analog configuration chain.
- On a start request it captures the 128-bit analog configuration word held by the PMC analog-conf register block into a shadow register.
- It shifts the word MSB-first into the on-chip analog shift chain using a divided serial clock, then pulses a latch strobe so the chain output registers update in one step.
- It sits between the PMC analog-conf registers and the analog periphery, and reports busy/done to the PMC control logic.

Parameters:
- DATA_W, 128, configuration word width and number of bits shifted per load (>=2).
- CLK_DIV, 4, clk cycles per sclk half-period (>=1).
- LATCH_CYCLES, 2, clk cycles the latch strobe stays high (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load request, sampled on the rising clk edge; acted on only in IDLE.
- abort  input  1  cancels any load in progress; has priority over start.
- conf_in  input  DATA_W  configuration word; sampled only on the edge that accepts start.
- sclk  output  1  serial shift clock to the analog chain.
- sdata  output  1  serial data; changes only while sclk is low.
- latch  output  1  chain update strobe.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse marking successful completion.

Behaviour:
- Clock and reset: single clock domain, clk; reset is asynchronous, active-low (rst_n). All state is in flops.
- Reset values:
  - state = IDLE.
  - sclk = 0, sdata = 0, latch = 0, busy = 0, done = 0.
  - shadow register = 0, bit counter = 0, divider counter = 0.
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE:
  - All outputs are 0.
  - When start=1 and abort=0: shadow <= conf_in, bit counter <= DATA_W-1, divider <= 0, go to SHIFT.
- SHIFT:
  - busy=1. sdata = shadow[DATA_W-1].
  - Each bit occupies 2*CLK_DIV clk cycles: sclk=0 for the first CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - The chain captures data on the sclk rising edge.
  - On the last cycle of the high phase: shift shadow left by one (LSB filled with 0), decrement the bit counter, and sclk returns to 0 on the next cycle.
  - After the high phase of bit 0 completes: go to LATCH. sclk=0 and sdata=0 from then on.
  - Shift phase lasts exactly DATA_W*2*CLK_DIV cycles.
- LATCH:
  - busy=1, latch=1 for exactly LATCH_CYCLES cycles, sclk=0.
  - Then go to DONE.
- DONE:
  - busy=1, done=1 for one cycle, then go to IDLE.
  - busy=0 from the following cycle.
- Latency: with start accepted on edge 0, busy is first high in cycle 1, and done is high in cycle 1 + DATA_W*2*CLK_DIV + LATCH_CYCLES.
- Boundary conditions:
  - start while busy (SHIFT/LATCH/DONE): ignored. No restart and no re-capture of conf_in.
  - conf_in changing during a load: no effect, because the shadow register is used.
  - start held high continuously: a new load begins on the edge after DONE, when IDLE samples start. This gives back-to-back loads.
  - start and abort together in IDLE: nothing happens.
  - abort in any non-IDLE state: go to IDLE on the next edge. sclk, latch and sdata drop to 0 and busy drops to 0 in that cycle; done is not pulsed.
  - abort during LATCH: latch deasserts immediately. The chain registers may be partially updated; software must reload.
  - Reset mid-operation: all outputs go to 0 immediately (asynchronously) and the load is lost.
  - Counters: the divider counts 0..2*CLK_DIV-1 and wraps; the bit counter is clog2(DATA_W) wide and never underflows, because the SHIFT exit is taken at count 0.

Test Plan:
- Basic load (DATA_W=128, CLK_DIV=1, LATCH_CYCLES=2): conf_in=128'h8000_..._0001, start pulse on edge 0 -> the first sclk rising edge samples sdata=1, the next 126 sample 0, the 128th samples 1. 128 sclk pulses total; latch high in cycles 257-258; done=1 in cycle 259 only; busy high in cycles 1-259.
- Divider timing (CLK_DIV=4): pattern 128'hAAAA... -> sclk period 8 cycles at 50% duty; sdata alternates 1,0,... and is stable at each sclk rise; done at cycle 1+1024+2=1027.
- Ignore while busy: second start at cycle 50 with a different conf_in -> the shifted data still equals the first word; exactly one done pulse.
- Abort at cycle 100 of a load -> next cycle busy=0, sclk=0, latch never asserted, no done. A subsequent start performs a full correct load.
- Reset mid-operation: rst_n low for 3 cycles during SHIFT -> outputs 0 asynchronously; after release state is IDLE and no done occurs until a new start.
- Continuous start with conf_in values A then B -> two complete loads back-to-back: the second begins the cycle after the first done, the second shifts B, and two done pulses occur.

Source files
------------

// File: rtl/pmc_ac_loader.sv
// Analog configuration chain loader: captures a configuration word, shifts it
// MSB-first on a divided serial clock, then strobes the chain latch.
module pmc_ac_loader #(
  parameter int DATA_W       = 128,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] conf_in,
  output logic              sclk,
  output logic              sdata,
  output logic              latch,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shadow, shadow_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DIV_W-1:0]  div_cnt, div_cnt_n;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_n;

  always_comb begin
    state_n   = state;
    shadow_n  = shadow;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    lat_cnt_n = lat_cnt;
    if (state != ST_IDLE && abort) begin
      state_n   = ST_IDLE;
      div_cnt_n = '0;
      lat_cnt_n = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            shadow_n  = conf_in;
            bit_cnt_n = BIT_W'(DATA_W - 1);
            div_cnt_n = '0;
            state_n   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // End of the high phase: advance to the next bit or leave after bit 0.
          if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
            div_cnt_n = '0;
            shadow_n  = {shadow[DATA_W-2:0], 1'b0};
            if (bit_cnt == '0) begin
              state_n   = ST_LATCH;
              lat_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt - 1'b1;
            end
          end else begin
            div_cnt_n = div_cnt + 1'b1;
          end
        end
        ST_LATCH: begin
          if (lat_cnt == LAT_W'(LATCH_CYCLES - 1)) begin
            lat_cnt_n = '0;
            state_n   = ST_DONE;
          end else begin
            lat_cnt_n = lat_cnt + 1'b1;
          end
        end
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they are glitch-free
  // and aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shadow  <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      lat_cnt <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shadow  <= shadow_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_cnt_n;
      lat_cnt <= lat_cnt_n;
      sclk    <= (state_n == ST_SHIFT) && (div_cnt_n >= DIV_W'(CLK_DIV));
      sdata   <= (state_n == ST_SHIFT) && shadow_n[DATA_W-1];
      latch   <= (state_n == ST_LATCH);
      busy    <= (state_n != ST_IDLE);
      done    <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pmc_ac_loader.sv
// Randomized bench for pmc_ac_loader against a cycle-offset reference model.
module tb_pmc_ac_loader;

  localparam int DW = 128;
  localparam int CD = 4;
  localparam int LC = 2;
  localparam int S  = DW * 2 * CD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] conf_in = '0;
  logic          sclk, sdata, latch, busy, done;

  pmc_ac_loader #(.DATA_W(DW), .CLK_DIV(CD), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .conf_in(conf_in),
    .sclk(sclk), .sdata(sdata), .latch(latch), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_no = 0;

  // Reference model: a load is described only by its accepted word and the
  // number of cycles elapsed since the accepting edge.
  bit            m_act = 1'b0;
  int            m_t = 0;
  logic [DW-1:0] m_word = '0;
  int            exp_dones = 0;
  int            obs_dones = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, obs, exp, cyc_no);
    end
  endtask

  function automatic logic [4:0] exp_out();
    int k, ph;
    if (!m_act) return 5'b0;
    if (m_t <= S) begin
      k  = (m_t - 1) / (2 * CD);
      ph = (m_t - 1) % (2 * CD);
      return {ph >= CD, m_word[DW-1-k], 1'b0, 1'b1, 1'b0};
    end
    if (m_t <= S + LC) return 5'b00110;
    return 5'b00011;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: check the current cycle, drive inputs for the next edge, advance the model.
  task automatic cyc(input bit s, input bit a, input logic [DW-1:0] c, input bit r);
    logic [4:0] e;
    @(negedge clk);
    cyc_no++;
    e = exp_out();
    chk("outs", {27'b0, sclk, sdata, latch, busy, done}, {27'b0, e});
    if (e[0]) exp_dones++;
    if (done) obs_dones++;
    start   = s;
    abort   = a;
    conf_in = c;
    rst_n   = r;
    if (!r) begin
      #1;
      chk("rst_async", {27'b0, sclk, sdata, latch, busy, done}, 32'h0);
      m_act = 1'b0;
    end else if (m_act) begin
      if (a || m_t == S + LC + 1) m_act = 1'b0;
      else m_t++;
    end else if (s && !a) begin
      m_act  = 1'b1;
      m_t    = 1;
      m_word = c;
    end
  endtask

  task automatic idle_until_done(input int limit);
    int n = 0;
    while (m_act && n < limit) begin
      cyc(1'b0, 1'b0, rnd_word(), 1'b1);
      n++;
    end
    if (m_act) chk("timeout", 32'd1, 32'd0);
    repeat (3) cyc(1'b0, 1'b0, rnd_word(), 1'b1);
  endtask

  task automatic check_dones(input string tag, input int want);
    chk(tag, 32'(obs_dones), 32'(want));
    chk({tag, "_model"}, 32'(obs_dones), 32'(exp_dones));
    obs_dones = 0;
    exp_dones = 0;
  endtask

  logic [DW-1:0] wa, wb;

  initial begin
    // Reset state
    #2;
    chk("reset_outs", {27'b0, sclk, sdata, latch, busy, done}, 32'h0);
    repeat (2) cyc(1'b1, 1'b0, rnd_word(), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);

    // Single set MSB and LSB
    wa = '0; wa[DW-1] = 1'b1; wa[0] = 1'b1;
    cyc(1'b1, 1'b0, wa, 1'b1);
    idle_until_done(3000);
    check_dones("done_basic", 1);

    // Alternating pattern
    wa = {(DW/2){2'b10}};
    cyc(1'b1, 1'b0, wa, 1'b1);
    idle_until_done(3000);
    check_dones("done_alt", 1);

    // Second start while busy with a different word
    cyc(1'b1, 1'b0, rnd_word(), 1'b1);
    repeat (49) cyc(1'b0, 1'b0, rnd_word(), 1'b1);
    cyc(1'b1, 1'b0, rnd_word(), 1'b1);
    idle_until_done(3000);
    check_dones("done_ignore", 1);

    // Abort mid-shift, then a full load
    cyc(1'b1, 1'b0, rnd_word(), 1'b1);
    repeat (99) cyc(1'b0, 1'b0, rnd_word(), 1'b1);
    cyc(1'b1, 1'b1, rnd_word(), 1'b1);
    repeat (4) cyc(1'b0, 1'b0, rnd_word(), 1'b1);
    check_dones("done_abort", 0);
    cyc(1'b1, 1'b0, rnd_word(), 1'b1);
    idle_until_done(3000);
    check_dones("done_after_abort", 1);

    // Abort during the latch strobe
    cyc(1'b1, 1'b0, rnd_word(), 1'b1);
    repeat (S) cyc(1'b0, 1'b0, rnd_word(), 1'b1);
    cyc(1'b0, 1'b1, rnd_word(), 1'b1);
    repeat (3) cyc(1'b0, 1'b0, rnd_word(), 1'b1);
    check_dones("done_abort_latch", 0);

    // Start and abort together while idle
    cyc(1'b1, 1'b1, rnd_word(), 1'b1);
    repeat (3) cyc(1'b0, 1'b0, rnd_word(), 1'b1);

    // Reset mid-shift
    cyc(1'b1, 1'b0, rnd_word(), 1'b1);
    repeat (200) cyc(1'b0, 1'b0, rnd_word(), 1'b1);
    repeat (3) cyc(1'b1, 1'b0, rnd_word(), 1'b0);
    repeat (20) cyc(1'b0, 1'b0, rnd_word(), 1'b1);
    check_dones("done_reset", 0);

    // Continuous start: A then B back-to-back
    wa = rnd_word();
    wb = rnd_word();
    cyc(1'b1, 1'b0, wa, 1'b1);
    repeat (2 * (S + LC + 1) + 2) cyc(1'b1, 1'b0, wb, 1'b1);
    cyc(1'b0, 1'b0, rnd_word(), 1'b1);
    idle_until_done(3000);
    check_dones("done_b2b", 3);

    // Random traffic with occasional aborts
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      cyc(1'b1, 1'b0, rnd_word(), 1'b1);
      while (m_act && n < 3000) begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1999) == 0, rnd_word(), 1'b1);
        n++;
      end
      if (m_act) chk("timeout_rand", 32'd1, 32'd0);
      cyc(1'b0, 1'b0, rnd_word(), 1'b1);
    end
    chk("done_rand_model", 32'(obs_dones), 32'(exp_dones));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
